// File: rtl/prim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prim_pkg
// Purpose  : Helpers shared by the prim_* primitives (width computation).
// Revision : 1.0 - initial release
// ============================================================================
package prim_pkg;

  // Ceiling log2 for elaboration-time width sizing; returns 0 for value <= 1.
  function automatic int prim_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prim_wrapcnt.sv
`default_nettype none
// ============================================================================
// Module   : prim_wrapcnt
// Purpose  : Enabled up-counter with synchronous clear that wraps to 0 after
//            MAX. MAX need not be 2^n-1.
// Revision : 1.0 - initial release
// ============================================================================
module prim_wrapcnt
  import prim_pkg::*;
#(
  parameter int  MAX = 1,
  localparam int W   = (MAX > 0) ? prim_clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear wins, otherwise advance and wrap at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/prim_elasticbuf.sv
`default_nettype none
// ============================================================================
// Module   : prim_elasticbuf
// Purpose  : DEPTH-entry valid/ready elastic buffer with fully registered
//            upstream ready, synchronous flush, occupancy and downstream stall.
// Revision : 1.0 - initial release
// ============================================================================
module prim_elasticbuf
  import prim_pkg::*;
#(
  parameter int  WIDTH           = 32,
  parameter int  DEPTH           = 2,
  parameter bit  ZERO_ON_INVALID = 1'b0,
  localparam int CW              = prim_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  output logic             urdy_o,
  input  logic             uvld_i,
  input  logic [WIDTH-1:0] udat_i,
  input  logic             dstall_i,
  input  logic             drdy_i,
  output logic             dvld_o,
  output logic [WIDTH-1:0] ddat_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? prim_clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;
  logic             urdy_d;
  logic             urdy_q;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rd_data;

  // Handshakes; flush suppresses both so nothing moves in the flush cycle.
  assign dvld_o = (count_q != '0) && !dstall_i;
  assign push   = uvld_i && urdy_q && !flush_i;
  assign pop    = dvld_o && drdy_i && !flush_i;

  prim_wrapcnt #(.MAX(DEPTH - 1)) u_wp (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (flush_i),
    .en_i    (push),
    .cnt_o   (wp)
  );

  prim_wrapcnt #(.MAX(DEPTH - 1)) u_rp (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (flush_i),
    .en_i    (pop),
    .cnt_o   (rp)
  );

  // Occupancy and registered ready; ready looks at next-state count only.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    urdy_d = (count_d != CW'(DEPTH));
  end

  // Occupancy/ready registers; ready is held low throughout reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      urdy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      urdy_q  <= urdy_d;
    end
  end

  // Single write port: only the entry at the write pointer takes new data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && (wp == PW'(i))) begin
        mem_d[i] = udat_i;
      end
    end
  end

  // Storage flops; reset clears them, flush deliberately does not.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Single read port as an explicit mux so non-power-of-two depths index safely.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rp == PW'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  // Zeroing keys off emptiness only; a stalled head still shows its data.
  assign ddat_o  = (ZERO_ON_INVALID && (count_q == '0)) ? '0 : rd_data;
  assign urdy_o  = urdy_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prim_elasticbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_elasticbuf
// Purpose  : Directed vector bench for prim_elasticbuf (DEPTH=4 zeroing
//            instance and DEPTH=3 wrap instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_elasticbuf;

  typedef struct {
    logic       flush;
    logic       uvld;
    logic [7:0] udat;
    logic       dstall;
    logic       drdy;
    logic       urdy;
    logic       dvld;
    logic [7:0] ddat;
    logic [2:0] cnt;
  } vec_t;

  logic       clk;
  logic       reset_n;

  logic       a_flush, a_uvld, a_dstall, a_drdy, a_urdy, a_dvld;
  logic [7:0] a_udat, a_ddat;
  logic [2:0] a_count;

  logic       b_flush, b_uvld, b_dstall, b_drdy, b_urdy, b_dvld;
  logic [7:0] b_udat, b_ddat;
  logic [1:0] b_count;

  int n_vec;
  int n_err;

  prim_elasticbuf #(.WIDTH(8), .DEPTH(4), .ZERO_ON_INVALID(1'b1)) u_dut4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (a_flush),
    .urdy_o   (a_urdy),
    .uvld_i   (a_uvld),
    .udat_i   (a_udat),
    .dstall_i (a_dstall),
    .drdy_i   (a_drdy),
    .dvld_o   (a_dvld),
    .ddat_o   (a_ddat),
    .count_o  (a_count)
  );

  prim_elasticbuf #(.WIDTH(8), .DEPTH(3), .ZERO_ON_INVALID(1'b0)) u_dut3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (b_flush),
    .urdy_o   (b_urdy),
    .uvld_i   (b_uvld),
    .udat_i   (b_udat),
    .dstall_i (b_dstall),
    .drdy_i   (b_drdy),
    .dvld_o   (b_dvld),
    .ddat_o   (b_ddat),
    .count_o  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic uv, input logic [7:0] ud,
                              input logic ds, input logic dr, input logic ur,
                              input logic dv, input logic [7:0] dd, input logic [2:0] c);
    vec_t v;
    v.flush = fl; v.uvld = uv; v.udat = ud; v.dstall = ds; v.drdy = dr;
    v.urdy = ur; v.dvld = dv; v.ddat = dd; v.cnt = c;
    return v;
  endfunction

  vec_t tbl [26];

  initial begin
    int sent, got, mcnt, cyc;
    n_vec = 0;
    n_err = 0;

    //            fl uv udat   ds dr | urdy dvld ddat  cnt
    tbl[0]  = mk(0, 1, 8'h11, 0, 0,   1,   0,   8'h00, 0); // fill
    tbl[1]  = mk(0, 1, 8'h22, 0, 0,   1,   1,   8'h11, 1);
    tbl[2]  = mk(0, 1, 8'h33, 0, 0,   1,   1,   8'h11, 2);
    tbl[3]  = mk(0, 1, 8'h44, 0, 0,   1,   1,   8'h11, 3);
    tbl[4]  = mk(0, 1, 8'h55, 0, 0,   0,   1,   8'h11, 4); // full, push blocked
    tbl[5]  = mk(0, 0, 8'h00, 0, 1,   0,   1,   8'h11, 4); // pop while full
    tbl[6]  = mk(0, 0, 8'h00, 0, 1,   1,   1,   8'h22, 3); // ready back
    tbl[7]  = mk(0, 1, 8'h66, 0, 1,   1,   1,   8'h33, 2); // push+pop, wp wraps
    tbl[8]  = mk(0, 0, 8'h00, 1, 0,   1,   0,   8'h44, 2); // stall keeps data
    tbl[9]  = mk(0, 1, 8'h77, 1, 1,   1,   0,   8'h44, 2); // stalled, still fills
    tbl[10] = mk(0, 1, 8'h88, 1, 1,   1,   0,   8'h44, 3);
    tbl[11] = mk(0, 0, 8'h00, 1, 1,   0,   0,   8'h44, 4);
    tbl[12] = mk(0, 0, 8'h00, 0, 1,   0,   1,   8'h44, 4); // release stall
    tbl[13] = mk(0, 0, 8'h00, 0, 1,   1,   1,   8'h66, 3);
    tbl[14] = mk(0, 0, 8'h00, 0, 1,   1,   1,   8'h77, 2);
    tbl[15] = mk(0, 1, 8'h99, 0, 1,   1,   1,   8'h88, 1); // push+pop at count 1
    tbl[16] = mk(0, 0, 8'h00, 0, 1,   1,   1,   8'h99, 1);
    tbl[17] = mk(0, 0, 8'h00, 0, 0,   1,   0,   8'h00, 0); // empty -> zeroed
    tbl[18] = mk(0, 1, 8'hA1, 0, 0,   1,   0,   8'h00, 0);
    tbl[19] = mk(0, 1, 8'hA2, 0, 0,   1,   1,   8'hA1, 1);
    tbl[20] = mk(0, 1, 8'hA3, 0, 0,   1,   1,   8'hA1, 2);
    tbl[21] = mk(1, 1, 8'hA4, 0, 1,   1,   1,   8'hA1, 3); // flush vs push/pop
    tbl[22] = mk(0, 0, 8'h00, 0, 0,   1,   0,   8'h00, 0);
    tbl[23] = mk(0, 1, 8'hB1, 0, 0,   1,   0,   8'h00, 0); // pointers restarted
    tbl[24] = mk(0, 0, 8'h00, 0, 1,   1,   1,   8'hB1, 1);
    tbl[25] = mk(0, 0, 8'h00, 0, 0,   1,   0,   8'h00, 0);

    reset_n  = 1'b0;
    a_flush  = 1'b0; a_uvld = 1'b0; a_udat = 8'h00; a_dstall = 1'b0; a_drdy = 1'b0;
    b_flush  = 1'b0; b_uvld = 1'b0; b_udat = 8'h00; b_dstall = 1'b0; b_drdy = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_urdy",  32'(a_urdy),  32'd0);
    chk("rst_dvld",  32'(a_dvld),  32'd0);
    chk("rst_ddat",  32'(a_ddat),  32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_count3", 32'(b_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors against the DEPTH=4 instance
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      a_flush  = tbl[i].flush;
      a_uvld   = tbl[i].uvld;
      a_udat   = tbl[i].udat;
      a_dstall = tbl[i].dstall;
      a_drdy   = tbl[i].drdy;
      #1;
      chk($sformatf("v%0d_urdy", i),  32'(a_urdy),  32'(tbl[i].urdy));
      chk($sformatf("v%0d_dvld", i),  32'(a_dvld),  32'(tbl[i].dvld));
      chk($sformatf("v%0d_ddat", i),  32'(a_ddat),  32'(tbl[i].ddat));
      chk($sformatf("v%0d_count", i), 32'(a_count), 32'(tbl[i].cnt));
    end

    // Reset mid-operation at count 2
    @(negedge clk);
    a_uvld = 1'b1; a_udat = 8'hC1; a_drdy = 1'b0; a_dstall = 1'b0; a_flush = 1'b0;
    @(negedge clk);
    a_udat = 8'hC2;
    @(negedge clk);
    a_uvld = 1'b0;
    #1;
    chk("mid_pre_count", 32'(a_count), 32'd2);
    chk("mid_pre_ddat",  32'(a_ddat),  32'hC1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_urdy",  32'(a_urdy),  32'd0);
    chk("mid_dvld",  32'(a_dvld),  32'd0);
    chk("mid_ddat",  32'(a_ddat),  32'd0);
    chk("mid_count", 32'(a_count), 32'd0);
    @(negedge clk);
    a_uvld = 1'b1; a_udat = 8'hAB;
    #1;
    chk("post_urdy", 32'(a_urdy), 32'd1);
    @(negedge clk);
    a_uvld = 1'b0;
    #1;
    chk("post_dvld",  32'(a_dvld),  32'd1);
    chk("post_ddat",  32'(a_ddat),  32'hAB);
    chk("post_count", 32'(a_count), 32'd1);
    @(negedge clk);
    a_drdy = 1'b1;
    @(negedge clk);
    a_drdy = 1'b0;

    // DEPTH=3 streaming with random downstream ready
    sent = 0; got = 0; mcnt = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      b_uvld = (sent < 10);
      b_udat = 8'(sent + 1);
      b_drdy = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("s%0d_count", cyc), 32'(b_count), 32'(mcnt));
      chk($sformatf("s%0d_le3", cyc), 32'(b_count <= 2'd3 && mcnt <= 3), 32'd1);
      if (b_dvld && b_drdy) begin
        chk($sformatf("s_beat%0d", got), 32'(b_ddat), 32'(got + 1));
        got++;
        mcnt--;
      end
      if (b_uvld && b_urdy) begin
        sent++;
        mcnt++;
      end
      cyc++;
    end
    if (got < 10) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: got %0d beats expected 10", got);
    end
    @(negedge clk);
    b_uvld = 1'b0; b_drdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prim_elasticbuf.md
# prim_elasticbuf

Parametrised elastic buffer, successor to the single-entry skid buffer. It decouples an upstream valid/ready producer from a downstream valid/ready consumer with DEPTH entries of WIDTH bits. Upstream ready is fully registered: there is no combinational path from `drdy_i` or `dstall_i` to `urdy_o`, so long pipelines can close timing. Adds a synchronous flush, an occupancy output and a downstream stall, and sits between pipeline stages wherever back-pressure must be broken.

## Interface
- `WIDTH`, 32, payload width in bits (≥1)
- `DEPTH`, 2, number of entries (≥1; need not be a power of two)
- `ZERO_ON_INVALID`, 0, 1 → `ddat_o` forced to all-zero whenever `dvld_o` is 0 because the buffer is empty
- `CW`, localparam = $clog2(DEPTH+1), width of `count_o`

- `clk`  in  1  single clock; all state updates on posedge
- `reset_n`  in  1  reset, synchronous, active-low
- `flush_i`  in  1  synchronous discard of all entries
- `urdy_o`  out  1  upstream ready (registered)
- `uvld_i`  in  1  upstream valid
- `udat_i`  in  WIDTH  upstream payload
- `dstall_i`  in  1  downstream stall; masks `dvld_o` and blocks pop
- `drdy_i`  in  1  downstream ready
- `dvld_o`  out  1  downstream valid
- `ddat_o`  out  WIDTH  downstream payload (head entry)
- `count_o`  out  CW  current occupancy, 0..DEPTH

## Operation
- Storage is a circular array `mem[DEPTH]` with write pointer `wp`, read pointer `rp` (0..DEPTH-1) and `count` (0..DEPTH).
- push = `uvld_i & urdy_o & !flush_i`; pop = `dvld_o & drdy_i & !flush_i`.
- Push writes `udat_i` to `mem[wp]` and advances `wp`. Pop advances `rp`. A pointer equal to DEPTH-1 wraps to 0; there is no modulo-2ⁿ assumption.
- count_next = count + push − pop. A simultaneous push and pop leaves the count unchanged, and is legal at any occupancy other than full. When full, `urdy_o` is 0, so no push can occur.
- `urdy_o` is a register holding `(count_next != DEPTH)`. It is not a function of `drdy_i` in the same cycle: a pop while full gives `urdy_o` = 1 one cycle later.
- `dvld_o` = `(count != 0) & !dstall_i`. `dstall_i` does not affect `urdy_o`: the buffer keeps filling while the downstream is stalled.
- `ddat_o` = `mem[rp]`. If ZERO_ON_INVALID = 1 and count = 0, `ddat_o` = 0. A stall alone does not zero the data.
- Payload is held stable while `dvld_o` = 1 and `drdy_i` = 0.
- `flush_i` = 1 takes priority over push and pop. Next cycle: count = 0, `wp` = `rp` = 0, `urdy_o` = 1. Storage contents are not cleared.
- Reset (`reset_n` = 0 at a clock edge) gives count = 0, `wp` = `rp` = 0, and all `mem` entries = 0. While `reset_n` is low, `urdy_o` is held at 0. Reset mid-stream discards all entries.

## Timing
- Reset values:
  - `urdy_o` = 0 while in reset; 1 on the first cycle after release
  - `dvld_o` = 0
  - `ddat_o` = 0
  - `count_o` = 0
- Latency: a push at edge N into an empty buffer gives `dvld_o` = 1 in cycle N+1 (1-cycle latency; no fall-through).
- Throughput: 1 beat/cycle sustained with DEPTH ≥ 2. With DEPTH = 1: 1 beat per 2 cycles, because ready is registered.
- `count_o` and `urdy_o` change only on clock edges. `dvld_o` has a combinational path only from `dstall_i`.

## Structure
- Shared `prim_pkg` holds a `prim_clog2`-style width helper, reused across primitives. No typedefs are needed.
- Sub-module `prim_wrapcnt #(.MAX(DEPTH-1))`: enable plus synchronous clear, wraps to 0 after MAX. Instanced twice, for `wp` and `rp`.
- Storage is flops (no RAM macro), with one write port and one read port.

## Test plan
- **Fill/drain:** DEPTH=4, WIDTH=8. Push 0x11, 0x22, 0x33, 0x44 with `drdy_i`=0 → `count_o`=4, `urdy_o`=0 in the cycle after the 4th push. Raise `drdy_i` → outputs are 0x11…0x44 in order, and `urdy_o` returns to 1 one cycle after the first pop.
- **Non-power-of-two wrap:** DEPTH=3. Stream 10 beats (0x01…0x0A) at full rate with random `drdy_i` → output order and values match the input exactly, and `count_o` never exceeds 3.
- **Stall:** 2 entries held, `dstall_i`=1 with `drdy_i`=1 for 3 cycles → `dvld_o`=0, no pop, `count_o`=2; continued pushes fill to DEPTH. On release, head 0 is the first beat out.
- **Flush vs. push:** `flush_i`=1 while `uvld_i`=1 and count=3 → next cycle `count_o`=0, `dvld_o`=0, and the pushed beat is discarded. With ZERO_ON_INVALID=1, `ddat_o`=0.
- **Reset mid-operation:** `reset_n`=0 for 1 cycle at count=2 → next cycle all outputs are 0. The first push after release (0xAB) appears on `ddat_o` one cycle later with `dvld_o`=1.
- **Simultaneous push/pop at count=1:** `count_o` stays 1 and data order is preserved.
